// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFlush
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory handshake, redirect input and instruction output.
interface rv32i_fetch_unit_if;
  import rv32i_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc4;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid, inst, inst_pc, inst_pc4,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid, inst, inst_pc, inst_pc4,
    output inst_ready
  );

endinterface

// File: rtl/rv32i_fetch_fifo.sv
// Registered DEPTH x XLEN FIFO holding fetched instruction words; flush beats push.
module rv32i_fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [XLEN-1:0]              push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [XLEN-1:0]              head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch stage: credit-limited in-order fetch, response FIFO, redirect with stale-drop flush.
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input logic                clock,
  input logic                reset,
  rv32i_fetch_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [XLEN-1:0] target;
  logic [CntW-1:0] out_q, out_d;
  logic            req_q, req_d;
  logic            grant, rsp, push, pop, accept_rsp;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty, fifo_full;
  logic [XLEN-1:0] fifo_head;
  logic [SumW-1:0] credit_used;

  assign target = word_align(bus.redirect_pc);
  assign grant  = req_q & bus.imem_gnt;
  // Responses with nothing outstanding are protocol errors (or pre-reset leftovers).
  assign rsp    = bus.imem_rvalid & (out_q != '0);
  assign out_d  = out_q + CntW'(grant) - CntW'(rsp);
  assign pop    = ~fifo_empty & bus.inst_ready;
  assign push   = rsp & accept_rsp & ~bus.redirect;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (bus.redirect && (out_d != '0)) state_d = StFlush;
      StFlush: if (out_d == '0) state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    accept_rsp = 1'b0;
    unique case (state_q)
      StRun:   accept_rsp = 1'b1;
      default: accept_rsp = 1'b0;
    endcase
  end

  always_comb begin
    // Every slot already claimed: buffered, in flight, or the request currently on the bus.
    credit_used = SumW'(fifo_count) + SumW'(out_q) + SumW'(req_q);
    fetch_pc_d  = fetch_pc_q;
    head_pc_d   = head_pc_q;
    if (bus.redirect) begin
      fetch_pc_d = target;
      head_pc_d  = target;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (pop)   head_pc_d  = head_pc_q + XLEN'(4);
    end

    if (bus.redirect || (state_d != StRun)) begin
      req_d = 1'b0;
    end else if (req_q && !bus.imem_gnt) begin
      req_d = 1'b1;
    end else begin
      req_d = (credit_used < SumW'(DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      out_q      <= '0;
      req_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      out_q      <= out_d;
      req_q      <= req_d;
    end
  end

  rv32i_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (bus.imem_rdata),
    .pop       (pop),
    .flush     (bus.redirect),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = ~fifo_empty;
  assign bus.inst       = fifo_empty ? NOP_INST : fifo_head;
  assign bus.inst_pc    = head_pc_q;
  assign bus.inst_pc4   = head_pc_q + XLEN'(4);

  push_never_full: assert property (@(posedge clock) disable iff (reset) push |-> !fifo_full);

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit with an in-order memory model and a PC scoreboard.
module tb_rv32i_fetch_unit;
  import rv32i_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rv32i_fetch_unit_if bus();

  rv32i_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model and scoreboard state
  logic        rsp_en = 1'b1;
  logic [31:0] mem_q[$];
  logic [31:0] exp_addr, exp_pc, last_granted;
  logic        saw_wrap;
  int          grant_cnt = 0;
  int          pop_cnt = 0;

  // Memory returns ~addr one or more cycles after grant; monitor checks grants and pops.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(posedge clock);
      #2;
      if (reset) begin
        mem_q.delete();
        bus.imem_rvalid = 1'b0;
      end else if (rsp_en && (mem_q.size() > 0)) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = ~mem_q.pop_front();
      end else begin
        bus.imem_rvalid = 1'b0;
      end
      @(negedge clock);
      if (reset) begin
        exp_addr     = 32'h0;
        exp_pc       = 32'h0;
        last_granted = 32'h0;
        saw_wrap     = 1'b0;
      end else begin
        if (bus.imem_req && bus.imem_gnt) begin
          check_eq("grant_addr", bus.imem_addr, exp_addr);
          if (last_granted == 32'hFFFF_FFFC && bus.imem_addr == 32'h0) saw_wrap = 1'b1;
          last_granted = bus.imem_addr;
          mem_q.push_back(bus.imem_addr);
          exp_addr = exp_addr + 32'd4;
          grant_cnt++;
        end
        if (bus.inst_valid && bus.inst_ready) begin
          check_eq("pop_pc", bus.inst_pc, exp_pc);
          check_eq("pop_pc4", bus.inst_pc4, exp_pc + 32'd4);
          check_eq("pop_inst", bus.inst, ~exp_pc);
          exp_pc = exp_pc + 32'd4;
          pop_cnt++;
        end
        if (bus.redirect) begin
          exp_addr = bus.redirect_pc & 32'hFFFF_FFFC;
          exp_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Leaves the bench at a negedge with reset just released; the next edge is BOOT -> RUN.
  task automatic do_reset();
    step(1);
    reset = 1'b1;
    bus.redirect = 1'b0;
    step(2);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic expect_bus(input string tag, input logic req, input logic [31:0] addr);
    check_eq({tag, "_req"}, bus.imem_req, req);
    check_eq({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, p0;
    logic found;
    bus.imem_gnt    = 1'b1;
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset state
    do_reset();
    expect_bus("rst", 1'b0, 32'h0);
    check_eq("rst_valid", bus.inst_valid, 1'b0);
    check_eq("rst_inst", bus.inst, 32'h0000_0013);
    check_eq("rst_pc", bus.inst_pc, 32'h0);
    check_eq("rst_pc4", bus.inst_pc4, 32'h4);

    // Minimum latency: req after edge 1, first instruction after edge 3
    step(1); @(negedge clock);
    expect_bus("lat1", 1'b1, 32'h0);
    check_eq("lat1_valid", bus.inst_valid, 1'b0);
    step(1); @(negedge clock);
    expect_bus("lat2", 1'b1, 32'h4);
    check_eq("lat2_valid", bus.inst_valid, 1'b0);
    step(1); @(negedge clock);
    check_eq("lat3_valid", bus.inst_valid, 1'b1);
    check_eq("lat3_pc", bus.inst_pc, 32'h0);
    check_eq("lat3_pc4", bus.inst_pc4, 32'h4);
    check_eq("lat3_inst", bus.inst, 32'hFFFF_FFFF);
    p0 = pop_cnt;
    step(20);
    check_eq("stream_progress", (pop_cnt - p0) >= 8, 1'b1);

    // Consumer stalled: only DEPTH requests go out, nothing is lost
    bus.inst_ready = 1'b0;
    do_reset();
    g0 = grant_cnt;
    step(11); @(negedge clock);
    check_eq("stall_grants", grant_cnt - g0, 2);
    check_eq("stall_req", bus.imem_req, 1'b0);
    check_eq("stall_valid", bus.inst_valid, 1'b1);
    check_eq("stall_pc", bus.inst_pc, 32'h0);
    bus.inst_ready = 1'b1;
    p0 = pop_cnt;
    step(12);
    check_eq("stall_resume", (pop_cnt - p0) >= 4, 1'b1);

    // Grant withheld: address must hold
    bus.imem_gnt = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1); @(negedge clock);
      expect_bus("nogrant", 1'b1, 32'h0);
    end
    step(1);
    bus.imem_gnt = 1'b1;
    g0 = grant_cnt;
    step(12);
    check_eq("nogrant_resume", (grant_cnt - g0) >= 4, 1'b1);

    // Redirect with two requests in flight: both responses are stale
    rsp_en = 1'b0;
    do_reset();
    step(3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    @(negedge clock);
    check_eq("flush_pre_req", bus.imem_req, 1'b0);
    step(1);
    bus.redirect = 1'b0;
    rsp_en       = 1'b1;
    @(negedge clock);
    expect_bus("flush_c4", 1'b0, 32'h100);
    check_eq("flush_c4_valid", bus.inst_valid, 1'b0);
    check_eq("flush_c4_pc", bus.inst_pc, 32'h100);
    check_eq("flush_c4_pc4", bus.inst_pc4, 32'h104);
    step(1); @(negedge clock);
    expect_bus("flush_c5", 1'b0, 32'h100);
    check_eq("flush_c5_valid", bus.inst_valid, 1'b0);
    step(1); @(negedge clock);
    expect_bus("flush_c6", 1'b1, 32'h100);
    p0 = pop_cnt;
    step(8);
    check_eq("flush_delivered", (pop_cnt - p0) >= 2, 1'b1);

    // Redirect together with a pop and a returning word
    do_reset();
    step(3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    @(negedge clock);
    check_eq("same_valid", bus.inst_valid, 1'b1);
    check_eq("same_pc", bus.inst_pc, 32'h0);
    step(1);
    bus.redirect = 1'b0;
    @(negedge clock);
    check_eq("same_next_valid", bus.inst_valid, 1'b0);
    check_eq("same_next_inst", bus.inst, 32'h0000_0013);
    check_eq("same_next_pc", bus.inst_pc, 32'h200);
    expect_bus("same_next", 1'b0, 32'h200);
    step(1); @(negedge clock);
    expect_bus("same_restart", 1'b1, 32'h200);
    p0 = pop_cnt;
    step(8);
    check_eq("same_delivered", (pop_cnt - p0) >= 2, 1'b1);

    // PC wrap at 2^32
    do_reset();
    step(1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    step(1);
    bus.redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (bus.inst_valid && bus.inst_pc == 32'hFFFF_FFFC) found = 1'b1;
    end
    check_eq("wrap_found", found, 1'b1);
    if (found) begin
      check_eq("wrap_pc4", bus.inst_pc4, 32'h0);
      check_eq("wrap_inst", bus.inst, 32'h0000_0003);
    end
    step(10);
    check_eq("wrap_addr", saw_wrap, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
